multi_channel_event_counter: RTL and testbench

//  Parametrised N-channel event counter; next generation of the single-channel one-shot + sync counter chain.

---
 rtl/multi_channel_event_counter.sv | 177 +++++++++++++++++
 tb/tb_multi_channel_event_counter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_event_counter.sv
// N-channel event counter: synchronised rising-edge detect, per-channel count, snapshot and registered readout mux.
// Define EVENT_CNT_DEBOUNCE_EN to add a DEB_CYCLES stability filter to each channel's edge FSM.
module multi_channel_event_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0,
  parameter int DEB_CYCLES  = 16,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [NUM_CH-1:0] clear_mask,
  input  logic              snap,
  input  logic              view_live,
  input  logic [SEL_W-1:0]  ch_sel,
  output logic [CNT_W-1:0]  count_out,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] event_pulse
);

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 8 || CNT_W > 32 || SYNC_STAGES < 2 ||
      SYNC_STAGES > 4 || DEB_CYCLES < 1 || DEB_CYCLES > 65535) begin : g_param_check
    $error("multi_channel_event_counter: parameter out of range");
  end

`ifdef EVENT_CNT_DEBOUNCE_EN
  typedef enum logic [1:0] {ST_LOW, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK} edge_st_t;
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
  logic [15:0] stab_q [NUM_CH];
  logic [15:0] stab_d [NUM_CH];
`else
  typedef enum logic {ST_LOW, ST_HIGH} edge_st_t;
`endif

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      level;
  edge_st_t               state_q [NUM_CH];
  edge_st_t               state_d [NUM_CH];
  logic [NUM_CH-1:0]      pulse_d;
  logic [NUM_CH-1:0]      pulse_q;
  logic [CNT_W-1:0]       cnt_q [NUM_CH];
  logic [CNT_W-1:0]       shadow_q [NUM_CH];
  logic [NUM_CH-1:0]      ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], event_in[i]};
    end
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < NUM_CH; i++) level[i] = sync_q[i][SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_LOW;
`ifdef EVENT_CNT_DEBOUNCE_EN
        stab_q[i]  <= '0;
`endif
      end
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
`ifdef EVENT_CNT_DEBOUNCE_EN
        stab_q[i]  <= stab_d[i];
`endif
      end
      pulse_q <= pulse_d;
    end
  end

  // Pulse only on entry to HIGH; a held-high input produces a single event.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
`ifdef EVENT_CNT_DEBOUNCE_EN
      stab_d[i] = stab_q[i];
      case (state_q[i])
        ST_LOW: begin
          if (level[i]) begin
            state_d[i] = ST_RISE_CHK;
            stab_d[i]  = '0;
          end
        end
        ST_RISE_CHK: begin
          if (!level[i]) begin
            state_d[i] = ST_LOW;
          end else if (stab_q[i] == DEB_LAST) begin
            state_d[i] = ST_HIGH;
            pulse_d[i] = 1'b1;
          end else begin
            stab_d[i] = stab_q[i] + 16'd1;
          end
        end
        ST_HIGH: begin
          if (!level[i]) begin
            state_d[i] = ST_FALL_CHK;
            stab_d[i]  = '0;
          end
        end
        ST_FALL_CHK: begin
          if (level[i]) begin
            state_d[i] = ST_HIGH;
          end else if (stab_q[i] == DEB_LAST) begin
            state_d[i] = ST_LOW;
          end else begin
            stab_d[i] = stab_q[i] + 16'd1;
          end
        end
        default: state_d[i] = ST_LOW;
      endcase
`else
      case (state_q[i])
        ST_LOW: begin
          if (level[i]) begin
            state_d[i] = ST_HIGH;
            pulse_d[i] = 1'b1;
          end
        end
        ST_HIGH: begin
          if (!level[i]) state_d[i] = ST_LOW;
        end
        default: state_d[i] = ST_LOW;
      endcase
`endif
    end
  end

  // Shadow samples pre-update counts; clear takes priority over a coincident event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (snap) shadow_q[i] <= cnt_q[i];
        if (clear_mask[i]) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (pulse_q[i]) begin
          if (&cnt_q[i]) begin
            ovf_q[i] <= 1'b1;
            if (SATURATE == 0) cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_out <= '0;
    end else if (int'(ch_sel) < NUM_CH) begin
      count_out <= view_live ? cnt_q[ch_sel] : shadow_q[ch_sel];
    end else begin
      count_out <= '0;
    end
  end

  assign overflow    = ovf_q;
  assign event_pulse = pulse_q;

endmodule

// File: tb/tb_multi_channel_event_counter.sv
// Directed bench: a wrapping and a saturating counter instance driven by identical stimulus.
module tb_multi_channel_event_counter;

`ifdef EVENT_CNT_DEBOUNCE_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 1;
`endif
  localparam int FLUSH = 14;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] event_in;
  logic [4:0] clear_mask;
  logic       snap;
  logic       view_live;
  logic [2:0] ch_sel;
  logic [7:0] count_w, count_s;
  logic [4:0] ovf_w, ovf_s, ep_w, ep_s;

  int total = 0;
  int bad   = 0;
  int ep0_cnt = 0;

  typedef struct {
    logic [2:0] sel;
    logic       live;
    logic [7:0] exp;
  } vec_t;

  vec_t tab1 [5];
  vec_t tab4 [11];

  always #5 clk = ~clk;

  multi_channel_event_counter #(
    .NUM_CH(5), .CNT_W(8), .SYNC_STAGES(2), .SATURATE(0), .DEB_CYCLES(4)
  ) dut_w (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .clear_mask(clear_mask),
    .snap(snap), .view_live(view_live), .ch_sel(ch_sel),
    .count_out(count_w), .overflow(ovf_w), .event_pulse(ep_w)
  );

  multi_channel_event_counter #(
    .NUM_CH(5), .CNT_W(8), .SYNC_STAGES(2), .SATURATE(1), .DEB_CYCLES(4)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .clear_mask(clear_mask),
    .snap(snap), .view_live(view_live), .ch_sel(ch_sel),
    .count_out(count_s), .overflow(ovf_s), .event_pulse(ep_s)
  );

  always @(negedge clk) if (ep_w[0]) ep0_cnt = ep0_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [4:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      event_in = event_in | mask;
      repeat (HOLD) @(negedge clk);
      event_in = event_in & ~mask;
      repeat (HOLD) @(negedge clk);
    end
  endtask

  task automatic read(input string name, input logic [2:0] sel, input logic live,
                      input logic [7:0] exp_w, input logic [7:0] exp_s);
    ch_sel    = sel;
    view_live = live;
    @(negedge clk);
    check({name, "_wrap"}, count_w, exp_w);
    check({name, "_sat"}, count_s, exp_s);
  endtask

  task automatic do_clear(input logic [4:0] mask);
    clear_mask = mask;
    @(negedge clk);
    clear_mask = '0;
  endtask

  initial begin
    int  e0;
    bit  found;

    tab1[0] = '{3'd0, 1'b1, 8'd5};
    tab1[1] = '{3'd1, 1'b1, 8'd0};
    tab1[2] = '{3'd2, 1'b1, 8'd0};
    tab1[3] = '{3'd3, 1'b1, 8'd0};
    tab1[4] = '{3'd4, 1'b1, 8'd0};

    tab4[0]  = '{3'd0, 1'b0, 8'd3};
    tab4[1]  = '{3'd1, 1'b0, 8'd7};
    tab4[2]  = '{3'd2, 1'b0, 8'd0};
    tab4[3]  = '{3'd3, 1'b0, 8'd1};
    tab4[4]  = '{3'd4, 1'b0, 8'd0};
    tab4[5]  = '{3'd0, 1'b1, 8'd5};
    tab4[6]  = '{3'd1, 1'b1, 8'd7};
    tab4[7]  = '{3'd3, 1'b1, 8'd1};
    tab4[8]  = '{3'd5, 1'b1, 8'd0};
    tab4[9]  = '{3'd7, 1'b0, 8'd0};
    tab4[10] = '{3'd6, 1'b1, 8'd0};

    reset_n = 1'b0; event_in = '0; clear_mask = '0; snap = 1'b0; view_live = 1'b1; ch_sel = '0;
    repeat (3) @(negedge clk);
    check("reset_count_wrap", count_w, 0);
    check("reset_count_sat", count_s, 0);
    check("reset_ovf", ovf_w, 0);
    check("reset_pulse", ep_w, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // five clean pulses on channel 0
    e0 = ep0_cnt;
    pulse(5'b00001, 5);
    repeat (FLUSH) @(negedge clk);
    check("ch0_pulses_seen", ep0_cnt - e0, 5);
    for (int i = 0; i < 5; i++) read($sformatf("t1_sel%0d", i), tab1[i].sel, tab1[i].live, tab1[i].exp, tab1[i].exp);

    // counts {3,7,0,1,0}, snapshot, then two more on ch0
    do_clear(5'b00001);
    read("clr_ch0", 3'd0, 1'b1, 8'd0, 8'd0);
    pulse(5'b01010, 1);
    pulse(5'b00010, 6);
    pulse(5'b00001, 3);
    repeat (FLUSH) @(negedge clk);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    pulse(5'b00001, 2);
    repeat (FLUSH) @(negedge clk);
    for (int i = 0; i < 11; i++) read($sformatf("t4_vec%0d", i), tab4[i].sel, tab4[i].live, tab4[i].exp, tab4[i].exp);

    // snap coincident with clear: shadow holds pre-clear value
    clear_mask = 5'b00010;
    snap = 1'b1;
    @(negedge clk);
    clear_mask = '0;
    snap = 1'b0;
    read("snapclr_shadow", 3'd1, 1'b0, 8'd7, 8'd7);
    read("snapclr_live", 3'd1, 1'b1, 8'd0, 8'd0);

    // 256 events on ch1, then clear; 300 events on ch2
    pulse(5'b00010, 256);
    repeat (FLUSH) @(negedge clk);
    read("ch1_256", 3'd1, 1'b1, 8'd0, 8'd255);
    check("ovf_256_wrap", ovf_w, 5'b00010);
    check("ovf_256_sat", ovf_s, 5'b00010);
    do_clear(5'b00010);
    read("ch1_cleared", 3'd1, 1'b1, 8'd0, 8'd0);
    check("ovf_clr_wrap", ovf_w, 0);
    check("ovf_clr_sat", ovf_s, 0);
    pulse(5'b00100, 300);
    repeat (FLUSH) @(negedge clk);
    read("ch2_300", 3'd2, 1'b1, 8'd44, 8'd255);
    check("ovf_300_wrap", ovf_w, 5'b00100);
    check("ovf_300_sat", ovf_s, 5'b00100);

    // clear on the same cycle as a ch0 event pulse
    e0 = ep0_cnt;
    ch_sel = 3'd0; view_live = 1'b1;
    event_in[0] = 1'b1;
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (ep_w[0]) found = 1;
    end
    check("collide_pulse_found", 32'(found), 1);
    clear_mask = 5'b00001;
    @(negedge clk);
    clear_mask = '0;
    repeat (100) @(negedge clk);
    check("collide_pulses", ep0_cnt - e0, 1);
    read("collide_cnt", 3'd0, 1'b1, 8'd0, 8'd0);
    check("collide_ovf", ovf_w, 5'b00100);

    // long high counts once
    event_in[0] = 1'b0;
    repeat (FLUSH) @(negedge clk);
    e0 = ep0_cnt;
    event_in[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("held_pulses", ep0_cnt - e0, 1);
    read("held_cnt", 3'd0, 1'b1, 8'd1, 8'd1);

    // reset mid-operation with input still high
    reset_n = 1'b0;
    #2;
    check("midrst_count", count_w, 0);
    check("midrst_ovf_wrap", ovf_w, 0);
    check("midrst_ovf_sat", ovf_s, 0);
    @(negedge clk);
    e0 = ep0_cnt;
    reset_n = 1'b1;
    repeat (FLUSH) @(negedge clk);
    check("post_rst_pulses", ep0_cnt - e0, 1);
    read("post_rst_cnt", 3'd0, 1'b1, 8'd1, 8'd1);
    event_in[0] = 1'b0;
    repeat (FLUSH) @(negedge clk);

`ifdef EVENT_CNT_DEBOUNCE_EN
    // 3-cycle glitch is filtered
    e0 = ep0_cnt;
    event_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    event_in[0] = 1'b0;
    repeat (FLUSH) @(negedge clk);
    check("deb_glitch_pulses", ep0_cnt - e0, 0);
    read("deb_glitch_cnt", 3'd0, 1'b1, 8'd1, 8'd1);

    // 6-cycle high counts
    event_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    event_in[0] = 1'b0;
    repeat (FLUSH) @(negedge clk);
    check("deb_six_pulses", ep0_cnt - e0, 1);
    read("deb_six_cnt", 3'd0, 1'b1, 8'd2, 8'd2);

    // 3-cycle low dip while high adds nothing
    e0 = ep0_cnt;
    event_in[0] = 1'b1;
    repeat (FLUSH) @(negedge clk);
    check("deb_rise_pulses", ep0_cnt - e0, 1);
    event_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    event_in[0] = 1'b1;
    repeat (FLUSH) @(negedge clk);
    check("deb_dip_pulses", ep0_cnt - e0, 1);
    read("deb_dip_cnt", 3'd0, 1'b1, 8'd3, 8'd3);
    event_in[0] = 1'b0;
    repeat (FLUSH) @(negedge clk);

    // reset while in RISE_CHK
    e0 = ep0_cnt;
    event_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #2;
    check("deb_rst_count", count_w, 0);
    check("deb_rst_pulse", ep_w, 0);
    event_in[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (FLUSH) @(negedge clk);
    check("deb_rst_pulses", ep0_cnt - e0, 0);
    read("deb_rst_cnt", 3'd0, 1'b1, 8'd0, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
